// File: rtl/rle_pkg.sv
// Shared constants and FSM state types for the RLE scan-line receiver.
package rle_pkg;

  localparam logic MARKING   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic BIANCO    = 1'b0;
  localparam logic NERO      = 1'b1;

  localparam logic [7:0] EOL_BYTE  = 8'h00;
  localparam logic [7:0] BAD_BYTE  = 8'h01;
  localparam int FRAME_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    R_WAIT,
    R_IDLE,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_OFFER,
    O_ACK,
    O_REL
  } out_state_e;

endpackage

// File: rtl/rle_rx_decoder_if.sv
// Pixel handshake toward the sink: dav_ (active-low) / rfd.
interface rle_rx_decoder_if;
  logic colore;
  logic endline;
  logic dav_;
  logic rfd;

  modport master (
    output colore, endline, dav_,
    input  rfd
  );

  modport slave (
    input  colore, endline, dav_,
    output rfd
  );
endinterface

// File: rtl/rle_byte_fifo.sv
// Small byte FIFO; same-cycle push and pop allowed, also when full.
module rle_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // storage array, not reset: only reachable through the pointers
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rle_rx_decoder.sv
// Serial RLE scan-line receiver: deframes bytes, buffers them,
// and replays each run as pixels over the dav_/rfd handshake.
module rle_rx_decoder
  import rle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic rxd,
  rle_rx_decoder_if.master px,
  output logic err_frame,
  output logic err_ovf,
  output logic err_code
);

  rx_state_e  rx_state;
  out_state_e out_state;
  logic [3:0] cnt;
  logic [7:0] sr;
  logic [6:0] rem;
  logic       dav_q;
  logic       colore_q;
  logic       endline_q;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push_req;
  logic       pop;

  assign push_req = (rx_state == R_STOP) && (rxd == STOP_BIT);
  assign pop      = (out_state == O_IDLE) && !fifo_empty;

  assign px.dav_    = dav_q;
  assign px.colore  = colore_q;
  assign px.endline = endline_q;

  rle_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (sr),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // receiver: resync on marking, then start/data/stop framing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state  <= R_WAIT;
      cnt       <= '0;
      sr        <= '0;
      err_frame <= 1'b0;
    end else begin
      unique case (rx_state)
        R_WAIT: begin
          if (rxd == MARKING) rx_state <= R_IDLE;
        end
        R_IDLE: begin
          if (rxd == START_BIT) begin
            cnt      <= 4'(FRAME_DATA_BITS);
            rx_state <= R_DATA;
          end
        end
        R_DATA: begin
          sr  <= {rxd, sr[7:1]};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) rx_state <= R_STOP;
        end
        R_STOP: begin
          if (rxd == STOP_BIT) begin
            rx_state <= R_IDLE;
          end else begin
            err_frame <= 1'b1;
            rx_state  <= R_WAIT;
          end
        end
        default: rx_state <= R_WAIT;
      endcase
    end
  end

  // overflow flag: a completed byte found no room in the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_ovf <= 1'b0;
    else if (push_req && fifo_full && !pop) err_ovf <= 1'b1;
  end

  // output side: decode popped byte, then one handshake per pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_state <= O_IDLE;
      dav_q     <= 1'b1;
      colore_q  <= BIANCO;
      endline_q <= 1'b0;
      rem       <= '0;
      err_code  <= 1'b0;
    end else begin
      unique case (out_state)
        O_IDLE: begin
          if (!fifo_empty) begin
            unique case (1'b1)
              (fifo_dout == EOL_BYTE): begin
                endline_q <= 1'b1;
                colore_q  <= BIANCO;
                rem       <= 7'd1;
                out_state <= O_OFFER;
              end
              (fifo_dout == BAD_BYTE): begin
                err_code <= 1'b1;
              end
              default: begin
                endline_q <= 1'b0;
                colore_q  <= fifo_dout[0];
                rem       <= fifo_dout[7:1];
                out_state <= O_OFFER;
              end
            endcase
          end
        end
        O_OFFER: begin
          if (px.rfd) begin
            dav_q     <= 1'b0;
            out_state <= O_ACK;
          end
        end
        O_ACK: begin
          if (!px.rfd) begin
            dav_q     <= 1'b1;
            rem       <= rem - 7'd1;
            out_state <= O_REL;
          end
        end
        O_REL: begin
          if (px.rfd) begin
            out_state <= (rem != '0) ? O_OFFER : O_IDLE;
          end
        end
        default: out_state <= O_IDLE;
      endcase
    end
  end

endmodule
